// File: rtl/flash_block_buffer.sv
// flash_block_buffer
//   One-block (128 x 32-bit word) write-back buffer in front of the block BPI
//   flash controller. The CPU side is a word-addressed strobe/ack port; a miss
//   writes back the held block if dirty, then refills from the new block.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   cpu_addr/we/stb/data_i    CPU request (stb held until ack)
//   cpu_data_o, cpu_ack       read data and single-cycle completion pulse
//   fl_block_addr             block number to the controller
//   fl_we / fl_rd             block-write / block-read request levels
//   fl_data_o                 write data, buf[widx] (combinational read)
//   fl_data_i, fl_ack         read data (valid the cycle after ack), word ack
//   busy                      FSM not in IDLE
//   flush, flush_done         only with FLASH_BUF_FLUSH_EN defined: write the
//                             dirty block back without evicting it
//
// Build option: FLASH_BUF_FLUSH_EN adds the flush/flush_done port pair.

module flash_block_buffer #(
   parameter int ADDR_W     = 26,
   parameter int GAP_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_data_i,
   output logic [31:0]       cpu_data_o,
   input  logic              cpu_we,
   input  logic              cpu_stb,
   output logic              cpu_ack,
   output logic [25:0]       fl_block_addr,
   output logic [31:0]       fl_data_o,
   input  logic [31:0]       fl_data_i,
   output logic              fl_we,
   output logic              fl_rd,
   input  logic              fl_ack,
   output logic              busy
`ifdef FLASH_BUF_FLUSH_EN
   ,
   input  logic              flush,
   output logic              flush_done
`endif
);

   localparam int TAG_W = ADDR_W - 7;
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, RESP, WB, WB_GAP, FILL, FILL_GAP} state_t;
   state_t state, state_nx;

   logic [31:0]      mem [128];
   logic             valid, dirty, pend, started, ack_d;
   logic [TAG_W-1:0] tag, cpu_tag;
   logic [6:0]       widx, widx_d, cpu_off;
   logic [GAP_W-1:0] gap;
   logic             req, hit, gap_done, wb_done, fill_done;
   logic             flush_req, flush_op;

   assign cpu_tag   = cpu_addr[ADDR_W-1:7];
   assign cpu_off   = cpu_addr[6:0];
   // pend keeps a miss alive even if the master drops stb mid-transfer
   assign req       = cpu_stb | pend;
   assign hit       = valid && (tag == cpu_tag);
   assign gap_done  = (gap == GAP_W'(GAP_CYCLES - 1));
   assign wb_done   = fl_ack && (widx == 7'd127);
   // the 128th word lands one cycle after its ack
   assign fill_done = ack_d && (widx_d == 7'd127);
   assign fl_data_o = mem[widx];

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (req)                    state_nx = hit ? RESP : (dirty ? WB : FILL);
            else if (flush_req && dirty) state_nx = WB;
         end
         RESP:     state_nx = IDLE;
         WB:       if (wb_done)   state_nx = WB_GAP;
         WB_GAP:   if (gap_done)  state_nx = flush_op ? IDLE : FILL;
         FILL:     if (fill_done) state_nx = FILL_GAP;
         FILL_GAP: if (gap_done)  state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   // requests are levels dropped on the first word ack (started)
   always_comb begin
      cpu_ack       = 1'b0;
      fl_we         = 1'b0;
      fl_rd         = 1'b0;
      fl_block_addr = '0;
      busy          = (state != IDLE);
      case (state)
         RESP: cpu_ack = 1'b1;
         WB: begin
            fl_we         = !started;
            fl_block_addr = 26'(tag);
         end
         FILL: begin
            fl_rd         = !started;
            fl_block_addr = 26'(cpu_tag);
         end
         default: ;
      endcase
   end

   // ---------------- datapath / bookkeeping ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid      <= 1'b0;
         dirty      <= 1'b0;
         pend       <= 1'b0;
         started    <= 1'b0;
         ack_d      <= 1'b0;
         tag        <= '0;
         widx       <= '0;
         widx_d     <= '0;
         gap        <= '0;
         cpu_data_o <= '0;
      end else begin
         ack_d  <= (state == FILL) && fl_ack;
         widx_d <= widx;
         if ((state == WB_GAP || state == FILL_GAP) && state_nx == state)
            gap <= gap + GAP_W'(1);
         else
            gap <= '0;
         if (state == WB || state == FILL) begin
            if (fl_ack) started <= 1'b1;
         end else begin
            started <= 1'b0;
         end
         case (state)
            IDLE: if (req) begin
               if (hit) begin
                  pend <= 1'b0;
                  if (cpu_we) dirty      <= 1'b1;
                  else        cpu_data_o <= mem[cpu_off];
               end else begin
                  pend <= 1'b1;
               end
            end
            WB: if (fl_ack) begin
               widx <= widx + 7'd1;
               if (widx == 7'd127) dirty <= 1'b0;
            end
            FILL: begin
               if (fl_ack) widx <= widx + 7'd1;
               if (fill_done) begin
                  valid <= 1'b1;
                  tag   <= cpu_tag;
                  dirty <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // buffer storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (state == IDLE && req && hit && cpu_we) mem[cpu_off] <= cpu_data_i;
      if (state == FILL && ack_d)                mem[widx_d]  <= fl_data_i;
   end

`ifdef FLASH_BUF_FLUSH_EN
   // a flush only acts when no CPU request is pending
   assign flush_req = flush;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         flush_op   <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         if (state == IDLE && !req && flush) begin
            if (dirty) flush_op   <= 1'b1;
            else       flush_done <= 1'b1;
         end
         if (state == WB_GAP && gap_done && flush_op) begin
            flush_op   <= 1'b0;
            flush_done <= 1'b1;
         end
      end
   end
`else
   assign flush_req = 1'b0;
   assign flush_op  = 1'b0;
`endif

endmodule

// File: tb/tb_flash_block_buffer.sv
// tb_flash_block_buffer
//   Bench for flash_block_buffer: a block flash controller model with a
//   sparse flash image, a CPU-visible shadow memory feeding a read scoreboard,
//   and directed scenarios (cold fill with long init, hit, dirty eviction,
//   reset mid-fill, write miss and optional flush).

module tb_flash_block_buffer;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [25:0] cpu_addr = '0;
   logic [31:0] cpu_data_i = '0;
   logic [31:0] cpu_data_o;
   logic        cpu_we = 1'b0;
   logic        cpu_stb = 1'b0;
   logic        cpu_ack;
   logic [25:0] fl_block_addr;
   logic [31:0] fl_data_o;
   logic [31:0] fl_data_i;
   logic        fl_we, fl_rd;
   logic        fl_ack;
   logic        busy;
`ifdef FLASH_BUF_FLUSH_EN
   logic        flush = 1'b0;
   logic        flush_done;
`endif

   always #5 clk = ~clk;

   flash_block_buffer #(.ADDR_W(26), .GAP_CYCLES(3)) dut (
      .clk(clk), .rstn(rstn),
      .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
      .cpu_we(cpu_we), .cpu_stb(cpu_stb), .cpu_ack(cpu_ack),
      .fl_block_addr(fl_block_addr), .fl_data_o(fl_data_o), .fl_data_i(fl_data_i),
      .fl_we(fl_we), .fl_rd(fl_rd), .fl_ack(fl_ack), .busy(busy)
`ifdef FLASH_BUF_FLUSH_EN
      , .flush(flush), .flush_done(flush_done)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- flash controller model ----------------
   logic [31:0] flash_mem [int];
   logic [31:0] shadow [int];
   logic [63:0] op_q [$];
   int          init_cycles = 30000;
   int          m_phase = 0, m_n = 0, m_wait = 0, m_cool = 0, m_held = 0, m_held_max = 0;
   int          req_err = 0, both_err = 0, rd_hi = 0, we_hi = 0;
   logic        m_first = 1'b1, m_rd = 1'b0;
   logic [25:0] m_blk = '0;

   function automatic logic [31:0] fl_word(input int k);
      if (flash_mem.exists(k)) return flash_mem[k];
      return 32'hA000_0000 + 32'(k & 127);
   endfunction

   function automatic logic [31:0] exp_word(input logic [25:0] a);
      if (shadow.exists(int'(a))) return shadow[int'(a)];
      return 32'hA000_0000 + 32'(a[6:0]);
   endfunction

   initial begin
      fl_ack = 1'b0;
      fl_data_i = '0;
      forever begin
         @(negedge clk);
         if (fl_rd && fl_we) both_err++;
         if (fl_rd) rd_hi++;
         if (fl_we) we_hi++;
         if (!rstn) begin
            m_phase = 0;
            m_first = 1'b1;
            fl_ack  = 1'b0;
         end else begin
            case (m_phase)
               0: if (fl_rd || fl_we) begin
                  m_rd    = fl_rd;
                  m_blk   = fl_block_addr;
                  m_n     = 0;
                  m_wait  = m_first ? init_cycles : 1;
                  m_first = 1'b0;
                  m_held  = 0;
                  m_phase = 1;
               end
               1: begin
                  // request must stay up through the whole init wait
                  if ((m_rd && !fl_rd) || (!m_rd && !fl_we)) req_err++;
                  else m_held++;
                  if (m_held > m_held_max) m_held_max = m_held;
                  if (m_wait == 0) m_phase = 2;
                  else m_wait--;
               end
               2: begin
                  if (m_n >= 1 && (fl_rd || fl_we)) req_err++;
                  if (fl_ack) begin
                     fl_ack = 1'b0;
                     if (m_rd) fl_data_i = fl_word(int'(m_blk) * 128 + m_n - 1);
                     if (m_n == 128) begin
                        op_q.push_back({29'd0, m_rd, m_blk, 8'(m_n)});
                        m_phase = 3;
                        m_cool  = 2;
                     end
                  end else begin
                     if (!m_rd) flash_mem[int'(m_blk) * 128 + m_n] = fl_data_o;
                     fl_ack = 1'b1;
                     m_n++;
                  end
               end
               default: begin
                  if (m_cool <= 1) m_phase = 0;
                  else m_cool--;
               end
            endcase
         end
      end
   end

   // ---------------- read scoreboard ----------------
   logic [31:0] exp_q [$];

   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rstn && cpu_ack && !cpu_we) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk("rd_data", cpu_data_o, e);
         end
      end
   end

   task automatic cpu_access(input logic [25:0] a, input logic we, input logic [31:0] d,
                             output int lat);
      @(negedge clk);
      cpu_addr   = a;
      cpu_we     = we;
      cpu_data_i = d;
      cpu_stb    = 1'b1;
      if (we) shadow[int'(a)] = d;
      else    exp_q.push_back(exp_word(a));
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!cpu_ack && lat < 40000);
      chk("ack_seen", cpu_ack, 1);
      @(posedge clk);
      #1;
      cpu_stb = 1'b0;
      cpu_we  = 1'b0;
   endtask

   task automatic chk_op(input string tag, input logic rd, input logic [25:0] blk);
      logic [63:0] got;
      got = '1;
      if (op_q.size() != 0) got = op_q.pop_front();
      chk(tag, got, {29'd0, rd, blk, 8'd128});
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scenarios ----------------
   initial begin
      int lat, snap_rd, snap_we;
      repeat (2) @(negedge clk);
      chk("rst_ack", cpu_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fl_rd", fl_rd, 0);
      chk("rst_fl_we", fl_we, 0);
      chk("rst_baddr", fl_block_addr, 0);
      chk("rst_data_o", cpu_data_o, 0);
      rstn = 1'b1;

      // cold read miss behind a 30000-cycle controller init
      cpu_access(26'h085, 1'b0, 32'h0, lat);
      chk_op("t1_fill", 1'b1, 26'h1);
      chk("t1_init_hold", m_held_max >= 30000, 1);
      chk("t1_lat", lat > 30000, 1);
      init_cycles = 4;

      // read hit: one-cycle latency, no flash traffic
      snap_rd = rd_hi;
      cpu_access(26'h0FF, 1'b0, 32'h0, lat);
      chk("t2_hit_lat", lat, 1);
      chk("t2_no_rd", rd_hi - snap_rd, 0);

      // write hit then dirty eviction
      cpu_access(26'h090, 1'b1, 32'hDEAD_BEEF, lat);
      chk("t3_wr_lat", lat, 1);
      cpu_access(26'h200, 1'b0, 32'h0, lat);
      chk_op("t3_wb", 1'b0, 26'h1);
      chk_op("t3_fill", 1'b1, 26'h4);
      chk("t3_wb_w16", flash_mem[128 + 16], 32'hDEAD_BEEF);
      chk("t3_wb_w5", flash_mem[128 + 5], 32'hA000_0005);

      // reset in the middle of a fill
      @(negedge clk);
      cpu_addr = 26'h305;
      cpu_we   = 1'b0;
      cpu_stb  = 1'b1;
      for (int i = 0; i < 2000 && !(m_phase == 2 && m_n == 50); i++) @(negedge clk);
      chk("t4_reach50", m_n, 50);
      #2 rstn = 1'b0;
      #1;
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_rd", fl_rd, 0);
      chk("t4_rst_baddr", fl_block_addr, 0);
      cpu_stb = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      cpu_access(26'h210, 1'b0, 32'h0, lat);
      chk_op("t4_refill", 1'b1, 26'h4);

      // write miss into block 3
      cpu_access(26'h1A3, 1'b1, 32'h1234_5678, lat);
      chk_op("t5_fill", 1'b1, 26'h3);
`ifdef FLASH_BUF_FLUSH_EN
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      lat = 0;
      while (!flush_done && lat < 5000) begin
         @(negedge clk);
         lat++;
      end
      chk("t6_flush_done", flush_done, 1);
      chk_op("t6_flush_wb", 1'b0, 26'h3);
      chk("t6_flush_word", flash_mem[3 * 128 + 35], 32'h1234_5678);
      @(negedge clk);
      chk("t6_done_pulse", flush_done, 0);
      flush = 1'b1;
      @(negedge clk);
      chk("t6_clean_flush", flush_done, 1);
      flush = 1'b0;
`endif
      snap_rd = rd_hi;
      snap_we = we_hi;
      cpu_access(26'h1A3, 1'b0, 32'h0, lat);
      chk("t6_hit_lat", lat, 1);
      chk("t6_no_traffic", (rd_hi - snap_rd) + (we_hi - snap_we), 0);
      chk("t6_no_ops", op_q.size(), 0);

      chk("never_both", both_err, 0);
      chk("req_release", req_err, 0);
      chk("sb_empty", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
